fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. It holds the PC, the word-addressed instruction memory, and the IF/ID pipeline latch that feeds decode with the instruction and PC+1. It applies decode's redirect, stall and halt requests. A byte-serial load port lets the debug unit fill instruction memory before execution.

---
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/fetch_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: debug/load-port controls, decode hazard/redirect requests
// and the IF/ID outputs seen by decode and the debug unit.
interface fetch_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7,
    parameter int NB_BYTE = 8
);
    logic               i_enable;
    logic               i_load_mode;
    logic               i_load_clear;
    logic               i_load_valid;
    logic [NB_BYTE-1:0] i_load_byte;
    logic               i_pc_write;
    logic               i_IF_ID_write;
    logic               i_branch_or_jump;
    logic [1:0]         i_pc_src;
    logic [NB_ADDR-1:0] i_addr_branch;
    logic [NB_ADDR-1:0] i_addr_register;
    logic [NB_ADDR-1:0] i_addr_jump;
    logic               i_halt;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_ADDR-1:0] o_pc;
    logic [NB_ADDR-1:0] o_pc_current;
    logic [NB_ADDR:0]   o_load_count;
    logic               o_load_full;
    logic               o_halted;

    modport master (
        output i_enable, i_load_mode, i_load_clear, i_load_valid, i_load_byte,
               i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
               i_addr_branch, i_addr_register, i_addr_jump, i_halt,
        input  o_instruction, o_pc, o_pc_current, o_load_count, o_load_full, o_halted
    );

    modport slave (
        input  i_enable, i_load_mode, i_load_clear, i_load_valid, i_load_byte,
               i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
               i_addr_branch, i_addr_register, i_addr_jump, i_halt,
        output o_instruction, o_pc, o_pc_current, o_load_count, o_load_full, o_halted
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, word-addressed instruction memory with a
// byte-serial debug load port, and the IF/ID latch feeding decode.
module fetch_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7,
    parameter int NB_BYTE = 8
) (
    input logic          i_clock,
    input logic          i_reset,
    fetch_stage_if.slave bus
);
    localparam int BPW     = NB_DATA / NB_BYTE;
    localparam int NB_BCNT = $clog2(BPW);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BPW - 1);

    logic [NB_DATA-1:0]         mem [2**NB_ADDR];
    logic [NB_ADDR-1:0]         pc_p0;
    logic [NB_ADDR-1:0]         pc_inc_p0;
    logic [NB_ADDR-1:0]         target_p0;
    logic [NB_DATA-1:0]         instr_p1;
    logic [NB_ADDR-1:0]         pc_p1;
    logic                       halted;
    logic [NB_BCNT-1:0]         byte_cnt;
    logic [NB_ADDR:0]           load_count;
    logic [NB_DATA-NB_BYTE-1:0] word_asm;
    logic                       load_full;
    logic                       load_take;
    logic                       load_wr;
    logic                       run_ok;
    logic                       advance;
    logic                       stall;
    logic                       redirect;

    // Load port: a word is committed on its last byte; count's MSB doubles as "full"
    assign load_full = load_count[NB_ADDR];
    assign load_take = bus.i_load_mode && !bus.i_load_clear && bus.i_load_valid && !load_full;
    assign load_wr   = load_take && (byte_cnt == LAST_BYTE);

    assign run_ok    = !bus.i_load_mode && !halted && bus.i_enable;
    assign advance   = run_ok && !bus.i_halt;
    assign stall     = !bus.i_pc_write || !bus.i_IF_ID_write;
    assign redirect  = bus.i_branch_or_jump && !stall;
    assign pc_inc_p0 = pc_p0 + NB_ADDR'(1);

    always_comb begin
        target_p0 = pc_inc_p0;
        case (bus.i_pc_src)
            2'b01:   target_p0 = bus.i_addr_branch;
            2'b10:   target_p0 = bus.i_addr_register;
            2'b11:   target_p0 = bus.i_addr_jump;
            default: target_p0 = pc_inc_p0;
        endcase
    end

    // PC (p0) -> IF/ID latch (p1)
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pc_p0    <= '0;
            instr_p1 <= '0;
            pc_p1    <= '0;
            halted   <= 1'b0;
        end else begin
            if (run_ok && bus.i_halt)
                halted <= 1'b1;
            if (advance) begin
                if (bus.i_pc_write)
                    pc_p0 <= redirect ? target_p0 : pc_inc_p0;
                if (bus.i_IF_ID_write) begin
                    instr_p1 <= redirect ? '0 : mem[pc_p0];
                    pc_p1    <= pc_inc_p0;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt   <= '0;
            load_count <= '0;
        end else if (!bus.i_load_mode) begin
            byte_cnt <= '0;
        end else if (bus.i_load_clear) begin
            byte_cnt   <= '0;
            load_count <= '0;
        end else if (load_take) begin
            if (load_wr) begin
                byte_cnt   <= '0;
                load_count <= load_count + (NB_ADDR+1)'(1);
            end else begin
                byte_cnt <= byte_cnt + NB_BCNT'(1);
            end
        end
    end

    // Bytes arrive MSB-first, so the assembler shifts left
    always_ff @(posedge i_clock) begin
        if (load_take)
            word_asm <= {word_asm[NB_DATA-2*NB_BYTE-1:0], bus.i_load_byte};
        if (load_wr)
            mem[load_count[NB_ADDR-1:0]] <= {word_asm, bus.i_load_byte};
    end

    assign bus.o_instruction = bus.i_load_mode ? '0 : instr_p1;
    assign bus.o_pc          = pc_p1;
    assign bus.o_pc_current  = pc_p0;
    assign bus.o_load_count  = load_count;
    assign bus.o_load_full   = load_full;
    assign bus.o_halted      = halted;
endmodule
